fft_addr_gen: RTL

Parametrised butterfly address and twiddle-index generator for the in-place radix-2 DIT FFT stage. It generalises the per-stage coefficient mapper to any power-of-two length. It emits the operand pair addresses as well as the twiddle index, and it supports both single-stage and auto-sequenced all-stage runs. It also provides a programmable inter-stage drain gap, a stall input and inverse-transform conjugation. It sits between the FFT control sequencer and the sample RAM / twiddle ROM.

---
 rtl/fft_addr_gen_if.sv | 32 +++
 rtl/fft_addr_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fft_addr_gen_if.sv
// Control/address bus between the FFT sequencer (master) and the butterfly
// address generator (slave).
interface fft_addr_gen_if #(
  parameter int LOG2N = 4
);
  localparam int SW = $clog2(LOG2N);

  logic             start;
  logic             all_stages;
  logic [SW-1:0]    stage_in;
  logic             inverse;
  logic             stall;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             tw_conj;
  logic [SW-1:0]    stage;
  logic             valid;
  logic             last;
  logic             busy;
  logic             dv;

  modport master (
    output start, all_stages, stage_in, inverse, stall,
    input  addr_a, addr_b, tw_idx, tw_conj, stage, valid, last, busy, dv
  );

  modport slave (
    input  start, all_stages, stage_in, inverse, stall,
    output addr_a, addr_b, tw_idx, tw_conj, stage, valid, last, busy, dv
  );
endinterface

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT butterfly address / twiddle-index generator with
// single-stage or auto-sequenced all-stage runs, stall and inter-stage gap.
module fft_addr_gen #(
  parameter int LOG2N     = 4,
  parameter int STAGE_GAP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_addr_gen_if.slave bus
);
  localparam int SW    = $clog2(LOG2N);
  localparam int KW    = LOG2N - 1;
  localparam int GW    = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int GLAST = (STAGE_GAP > 0) ? STAGE_GAP - 1 : 0;
  localparam logic [SW-1:0] LAST_STG = SW'(LOG2N - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [SW-1:0] cur_stg;
  logic          all_r;
  logic [GW-1:0] gcnt;

  logic [LOG2N-1:0]   kx, span, mask, pos, a_c, b_c;
  logic [2*LOG2N-1:0] tw_wide;
  logic [KW-1:0]      tw_c;
  logic [SW-1:0]      start_stg;
  logic               k_last, more_stages;

  // group<<(s+1) is rewritten as (k with its low s bits cleared)<<1, and
  // pos<<(LOG2N-1-s) as ({pos,0}>>s)>>1, so no shift amount can overflow SW bits.
  always_comb begin
    kx      = LOG2N'(k);
    span    = LOG2N'(1) << cur_stg;
    mask    = span - LOG2N'(1);
    pos     = kx & mask;
    a_c     = ((kx & ~mask) << 1) | pos;
    b_c     = a_c | span;
    tw_wide = ({pos, {LOG2N{1'b0}}} >> cur_stg) >> 1;
    tw_c    = tw_wide[KW-1:0];
  end

  always_comb begin
    start_stg = '0;
    if (!bus.all_stages)
      start_stg = (32'(bus.stage_in) >= 32'(LOG2N)) ? LAST_STG : bus.stage_in;
    k_last      = (k == '1);
    more_stages = all_r && (cur_stg != LAST_STG);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      cur_stg     <= '0;
      all_r       <= 1'b0;
      gcnt        <= '0;
      bus.addr_a  <= '0;
      bus.addr_b  <= '0;
      bus.tw_idx  <= '0;
      bus.tw_conj <= 1'b0;
      bus.stage   <= '0;
      bus.valid   <= 1'b0;
      bus.last    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.dv      <= 1'b0;
    end else begin
      bus.dv <= 1'b0;
      case (state)
        IDLE: begin
          bus.valid <= 1'b0;
          bus.last  <= 1'b0;
          bus.busy  <= 1'b0;
          if (bus.start) begin
            all_r       <= bus.all_stages;
            cur_stg     <= start_stg;
            bus.tw_conj <= bus.inverse;
            k           <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          bus.busy <= 1'b1;
          if (bus.stall) begin
            bus.valid <= 1'b0;
            bus.last  <= 1'b0;
          end else begin
            bus.valid  <= 1'b1;
            bus.last   <= k_last;
            bus.addr_a <= a_c;
            bus.addr_b <= b_c;
            bus.tw_idx <= tw_c;
            bus.stage  <= cur_stg;
            k          <= k + KW'(1);
            if (k_last) begin
              if (!more_stages) begin
                state <= DONE;
              end else if (STAGE_GAP > 0) begin
                gcnt  <= '0;
                state <= GAP;
              end else begin
                cur_stg <= cur_stg + SW'(1);
              end
            end
          end
        end
        GAP: begin
          bus.valid <= 1'b0;
          bus.last  <= 1'b0;
          bus.busy  <= 1'b1;
          gcnt      <= gcnt + GW'(1);
          if (gcnt == GW'(GLAST)) begin
            cur_stg <= cur_stg + SW'(1);
            state   <= RUN;
          end
        end
        DONE: begin
          bus.valid <= 1'b0;
          bus.last  <= 1'b0;
          bus.busy  <= 1'b0;
          bus.dv    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
